// File: rtl/core_pkg.sv
// Shared core constants and helpers.
// Imported by every pipeline stage of the core.
package core_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    localparam int PC_INC = 4;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] inst;
    } if_id_t;

    function automatic logic misaligned(input logic [1:0] lo);
        return lo != 2'b00;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with squash, stall and bubble controls.
// accept flags the cycles where a real instruction is captured.
module if_id_reg
    import core_pkg::*;
#(
    parameter int              W        = XLEN,
    parameter logic [W-1:0]    NOP_WORD = NOP_INST
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         squash,
    input  logic         stall,
    input  logic         bubble,
    input  logic [W-1:0] fetch_pc,
    input  logic [W-1:0] fetch_inst,
    output logic         valid,
    output logic [W-1:0] pc,
    output logic [W-1:0] pc_plus4,
    output logic [W-1:0] inst,
    output logic         accept
);

    assign accept = rst_n & ~squash & ~stall & ~bubble;

    // Squash beats stall so a redirect never sees a stale instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            pc       <= '0;
            pc_plus4 <= '0;
            inst     <= NOP_WORD;
        end else if (squash) begin
            valid <= 1'b0;
            inst  <= NOP_WORD;
        end else if (stall) begin
            valid <= valid;
        end else if (bubble) begin
            valid <= 1'b0;
            inst  <= NOP_WORD;
        end else begin
            valid    <= 1'b1;
            pc       <= fetch_pc;
            pc_plus4 <= fetch_pc + W'(PC_INC);
            inst     <= fetch_inst;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads the instruction RAM
// and fills the IF/ID register for decode.
module if_fetch_stage
    import core_pkg::*;
#(
    parameter int           W         = XLEN,
    parameter logic [W-1:0] RESET_PC  = core_pkg::RESET_PC,
    parameter logic [W-1:0] NOP_INST  = core_pkg::NOP_INST
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         flush,
    input  logic         redirect_valid,
    input  logic [W-1:0] redirect_pc,
    input  logic         load_hold,
    output logic [W-1:0] pc,
    input  logic [W-1:0] inst_data,
    output logic         if_id_valid,
    output logic [W-1:0] if_id_pc,
    output logic [W-1:0] if_id_pc_plus4,
    output logic [W-1:0] if_id_inst,
    output logic         misalign_err,
    output logic [W-1:0] fetch_cnt
);

    logic [W-1:0] pc_q;
    logic [W-1:0] pc_next;
    logic         err_q;
    logic [W-1:0] cnt_q;
    logic         accept;

    assign pc           = pc_q;
    assign misalign_err = err_q;
    assign fetch_cnt    = cnt_q;

    // Redirect outranks stall/hold; low target bits are dropped.
    always_comb begin
        pc_next = pc_q + W'(PC_INC);
        if (redirect_valid)
            pc_next = {redirect_pc[W-1:2], 2'b00};
        else if (stall || load_hold)
            pc_next = pc_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            pc_q <= pc_next;
            if (redirect_valid && misaligned(redirect_pc[1:0]))
                err_q <= 1'b1;
            if (accept)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    if_id_reg #(
        .W        (W),
        .NOP_WORD (NOP_INST)
    ) u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .squash     (redirect_valid | flush),
        .stall      (stall),
        .bubble     (load_hold),
        .fetch_pc   (pc_q),
        .fetch_inst (inst_data),
        .valid      (if_id_valid),
        .pc         (if_id_pc),
        .pc_plus4   (if_id_pc_plus4),
        .inst       (if_id_inst),
        .accept     (accept)
    );

endmodule
